// File: rtl/seven_seg_scan_driver.sv
// Time-multiplexed N-digit seven-segment driver: double-buffered digit codes,
// per-slot dead time, leading-zero blanking and active-low segment decode.
module seven_seg_scan_driver #(
   parameter int N_DIGITS         = 4,
   parameter int REFRESH_DIV      = 100000,
   parameter int DEAD_CYCLES      = 500,
   parameter int ANODE_ACTIVE_LOW = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  load,
   input  logic [4*N_DIGITS-1:0] digits_in,
   input  logic [N_DIGITS-1:0]   dp_in,
   input  logic                  blank_lz,
   output logic [7:0]            seg,
   output logic [N_DIGITS-1:0]   an,
   output logic                  frame_done
);

   localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
   localparam logic [CNT_W-1:0]    CNT_LAST = CNT_W'(REFRESH_DIV - 1);
   localparam logic [IDX_W-1:0]    IDX_LAST = IDX_W'(N_DIGITS - 1);
   localparam logic [31:0]         DEAD_U   = 32'(DEAD_CYCLES);
   localparam logic [N_DIGITS-1:0] AN_OFF   = (ANODE_ACTIVE_LOW != 0) ? '1 : '0;

   function automatic logic [7:0] decode(input logic [3:0] code);
      logic [7:0] s;
      case (code)
         4'd0:    s = 8'b00000011;
         4'd1:    s = 8'b10011111;
         4'd2:    s = 8'b00100101;
         4'd3:    s = 8'b00001101;
         4'd4:    s = 8'b10011001;
         4'd5:    s = 8'b01001001;
         4'd6:    s = 8'b11000001;
         4'd7:    s = 8'b00011111;
         4'd8:    s = 8'b00000001;
         4'd9:    s = 8'b00011001;
         4'd10:   s = 8'b11111101;
         4'd15:   s = 8'b00000000;
         default: s = 8'b11111111;
      endcase
      return s;
   endfunction

   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic [IDX_W-1:0]      idx_q, idx_d;
   logic [4*N_DIGITS-1:0] act_code_q, act_code_d, pend_code_q, pend_code_d;
   logic [N_DIGITS-1:0]   act_dp_q, act_dp_d, pend_dp_q, pend_dp_d;
   logic                  act_blz_q, act_blz_d, pend_blz_q, pend_blz_d;
   logic                  pend_vld_q, pend_vld_d;
   logic [7:0]            seg_q, seg_d;
   logic [N_DIGITS-1:0]   an_q, an_d;
   logic                  fd_q, fd_d;

   logic                  boundary;
   logic                  run;
   logic [N_DIGITS-1:0]   blanked;
   logic [N_DIGITS-1:0]   onehot;
   logic [3:0]            code_sel;
   logic                  dp_sel;

   always_comb begin
      boundary = (cnt_q == CNT_LAST) && (idx_q == IDX_LAST);
      cnt_d    = cnt_q + 1'b1;
      idx_d    = idx_q;
      if (cnt_q == CNT_LAST) begin
         cnt_d = '0;
         idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
      end
      fd_d = boundary;
   end

   // Active buffer only moves on the frame boundary; a load on that exact
   // cycle bypasses the pending buffer so it is not delayed a whole frame.
   always_comb begin
      act_code_d  = act_code_q;
      act_dp_d    = act_dp_q;
      act_blz_d   = act_blz_q;
      pend_code_d = pend_code_q;
      pend_dp_d   = pend_dp_q;
      pend_blz_d  = pend_blz_q;
      pend_vld_d  = pend_vld_q;
      if (boundary) begin
         pend_vld_d = 1'b0;
         if (load) begin
            act_code_d = digits_in;
            act_dp_d   = dp_in;
            act_blz_d  = blank_lz;
         end else if (pend_vld_q) begin
            act_code_d = pend_code_q;
            act_dp_d   = pend_dp_q;
            act_blz_d  = pend_blz_q;
         end
      end else if (load) begin
         pend_code_d = digits_in;
         pend_dp_d   = dp_in;
         pend_blz_d  = blank_lz;
         pend_vld_d  = 1'b1;
      end
   end

   // Blanking runs from the most significant digit down and stops at the
   // first nonzero code or lit decimal point; digit 0 always shows.
   always_comb begin
      run      = act_blz_q;
      blanked  = '0;
      code_sel = 4'd0;
      dp_sel   = 1'b0;
      onehot   = '0;
      for (int i = N_DIGITS - 1; i >= 0; i--) begin
         if (i == 0 || act_code_q[4*i +: 4] != 4'd0 || act_dp_q[i]) run = 1'b0;
         blanked[i] = run;
      end
      for (int i = 0; i < N_DIGITS; i++) begin
         if (idx_q == IDX_W'(i)) begin
            code_sel  = blanked[i] ? 4'd11 : act_code_q[4*i +: 4];
            dp_sel    = act_dp_q[i];
            onehot[i] = 1'b1;
         end
      end
      if (32'(cnt_q) < DEAD_U) begin
         seg_d = 8'hFF;
         an_d  = AN_OFF;
      end else begin
         seg_d = decode(code_sel) & ~{7'b0, dp_sel};
         an_d  = (ANODE_ACTIVE_LOW != 0) ? ~onehot : onehot;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q       <= '0;
         idx_q       <= '0;
         act_code_q  <= '0;
         act_dp_q    <= '0;
         act_blz_q   <= 1'b0;
         pend_code_q <= '0;
         pend_dp_q   <= '0;
         pend_blz_q  <= 1'b0;
         pend_vld_q  <= 1'b0;
         seg_q       <= 8'hFF;
         an_q        <= AN_OFF;
         fd_q        <= 1'b0;
      end else begin
         cnt_q       <= cnt_d;
         idx_q       <= idx_d;
         act_code_q  <= act_code_d;
         act_dp_q    <= act_dp_d;
         act_blz_q   <= act_blz_d;
         pend_code_q <= pend_code_d;
         pend_dp_q   <= pend_dp_d;
         pend_blz_q  <= pend_blz_d;
         pend_vld_q  <= pend_vld_d;
         seg_q       <= seg_d;
         an_q        <= an_d;
         fd_q        <= fd_d;
      end
   end

   assign seg        = seg_q;
   assign an         = an_q;
   assign frame_done = fd_q;

endmodule

// File: tb/tb_seven_seg_scan_driver.sv
// Directed bench for seven_seg_scan_driver with a 4-digit, 8-cycle-slot,
// 2-dead-cycle configuration (32-cycle frames).
module tb_seven_seg_scan_driver;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        load = 1'b0;
   logic [15:0] digits_in = 16'h0;
   logic [3:0]  dp_in = 4'h0;
   logic        blank_lz = 1'b0;
   logic [7:0]  seg;
   logic [3:0]  an;
   logic        frame_done;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;

   seven_seg_scan_driver #(
      .N_DIGITS(4), .REFRESH_DIV(8), .DEAD_CYCLES(2), .ANODE_ACTIVE_LOW(1)
   ) dut (
      .clk(clk), .rst(rst), .load(load), .digits_in(digits_in), .dp_in(dp_in),
      .blank_lz(blank_lz), .seg(seg), .an(an), .frame_done(frame_done)
   );

   always #5 clk = ~clk;

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
         cyc++;
      end
   endtask

   task automatic goto_cyc(input int k);
      while (cyc < k) tick(1);
   endtask

   task automatic goto_frame();
      goto_cyc(((cyc + 31) / 32) * 32);
   endtask

   task automatic load_val(input logic [15:0] d, input logic [3:0] dp, input logic b);
      digits_in = d;
      dp_in     = dp;
      blank_lz  = b;
      load      = 1'b1;
      tick(1);
      load      = 1'b0;
   endtask

   // Entry must be right after a frame-boundary edge (cyc multiple of 32).
   task automatic check_frame(input string nm, input logic [7:0] s0, input logic [7:0] s1,
                              input logic [7:0] s2, input logic [7:0] s3);
      logic [7:0] exp_seg [4];
      logic [3:0] exp_an;
      exp_seg = '{s0, s1, s2, s3};
      for (int i = 0; i < 4; i++) begin
         exp_an = ~(4'b0001 << i);
         for (int d = 0; d < 2; d++) begin
            tick(1);
            n_checks++;
            if ({an, seg, frame_done} !== {4'b1111, 8'hFF, 1'b0}) begin
               n_fail++;
               $display("FAIL %s dead d%0d: an=%b seg=%b fd=%b, want an=1111 seg=11111111 fd=0",
                        nm, i, an, seg, frame_done);
            end
         end
         tick(1);
         n_checks++;
         if ({an, seg} !== {exp_an, exp_seg[i]}) begin
            n_fail++;
            $display("FAIL %s digit%0d: an=%b seg=%b, want an=%b seg=%b",
                     nm, i, an, seg, exp_an, exp_seg[i]);
         end
         tick(5);
      end
      n_checks++;
      if (frame_done !== 1'b1) begin
         n_fail++;
         $display("FAIL %s frame_done at cyc %0d: got %b, want 1", nm, cyc, frame_done);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick(3);
      n_checks++;
      if ({an, seg, frame_done} !== {4'b1111, 8'hFF, 1'b0}) begin
         n_fail++;
         $display("FAIL reset: an=%b seg=%b fd=%b, want 1111 11111111 0", an, seg, frame_done);
      end
      rst = 1'b0;
      cyc = 0;
   endtask

   task automatic test_idle();
      check_frame("idle0", 8'h03, 8'h03, 8'h03, 8'h03);
      check_frame("idle1", 8'h03, 8'h03, 8'h03, 8'h03);
   endtask

   task automatic test_double_buffer();
      load_val(16'h1234, 4'b0000, 1'b0);
      goto_cyc(cyc + 2);
      n_checks++;
      if ({an, seg} !== {4'b1110, 8'h03}) begin
         n_fail++;
         $display("FAIL dbuf midframe: an=%b seg=%b, want 1110 00000011", an, seg);
      end
      goto_frame();
      check_frame("dbuf", 8'b10011001, 8'b00001101, 8'b00100101, 8'b10011111);
   endtask

   task automatic test_blanking();
      load_val(16'h0007, 4'b0000, 1'b1);
      goto_frame();
      check_frame("blank7", 8'b00011111, 8'hFF, 8'hFF, 8'hFF);
      load_val(16'h0007, 4'b0000, 1'b0);
      goto_frame();
      check_frame("noblank7", 8'b00011111, 8'h03, 8'h03, 8'h03);
      load_val(16'h0000, 4'b0000, 1'b1);
      goto_frame();
      check_frame("blank0", 8'h03, 8'hFF, 8'hFF, 8'hFF);
   endtask

   task automatic test_sign_dp_lamp();
      load_val(16'hA05F, 4'b0010, 1'b1);
      goto_frame();
      check_frame("signdp", 8'b00000000, 8'b01001000, 8'b00000011, 8'b11111101);
   endtask

   task automatic test_back_to_back();
      load_val(16'h1111, 4'b0000, 1'b0);
      goto_cyc(cyc + 5);
      load_val(16'h2222, 4'b0000, 1'b0);
      goto_frame();
      check_frame("lastwins", 8'b00100101, 8'b00100101, 8'b00100101, 8'b00100101);
      goto_cyc(cyc + 31);
      load_val(16'h9999, 4'b0000, 1'b0);
      n_checks++;
      if (dut.pend_vld_q !== 1'b0) begin
         n_fail++;
         $display("FAIL boundary pending_valid: got %b, want 0", dut.pend_vld_q);
      end
      check_frame("boundary", 8'b00011001, 8'b00011001, 8'b00011001, 8'b00011001);
   endtask

   task automatic test_reset_midscan();
      int base;
      base = cyc;
      load_val(16'h5555, 4'b0000, 1'b0);
      goto_cyc(base + 19);
      n_checks++;
      if ({an, seg} !== {4'b1011, 8'b00011001}) begin
         n_fail++;
         $display("FAIL midscan pre-reset: an=%b seg=%b, want 1011 00011001", an, seg);
      end
      rst = 1'b1;
      tick(1);
      n_checks++;
      if ({an, seg, frame_done} !== {4'b1111, 8'hFF, 1'b0}) begin
         n_fail++;
         $display("FAIL midscan reset: an=%b seg=%b fd=%b, want 1111 11111111 0", an, seg, frame_done);
      end
      rst = 1'b0;
      cyc = 0;
      check_frame("postrst0", 8'h03, 8'h03, 8'h03, 8'h03);
      check_frame("postrst1", 8'h03, 8'h03, 8'h03, 8'h03);
   endtask

   initial begin
      test_reset();
      test_idle();
      test_double_buffer();
      test_blanking();
      test_sign_dp_lamp();
      test_back_to_back();
      test_reset_midscan();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
